// File: rtl/gpio_iobank.sv
// gpio_iobank: register-mapped bank of tristate pads with input synchronizers,
// edge detection, sticky W1C status and a level interrupt.
// Ports: clk, rst (sync, active-high), wr_en/addr/wr_data register write,
//        rd_data combinational read, io pads, in_sync/rise/fall, irq.
module gpio_iobank #(
    parameter int                 WIDTH       = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]   PULLUP_MASK = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    inout  wire  [WIDTH-1:0] io,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             irq
);

    localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] od_q;
    logic [WIDTH-1:0] ien_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [2:0]       warm_q;

    logic [WIDTH-1:0] drv_en;
    logic [WIDTH-1:0] drv_val;
    logic [WIDTH-1:0] rise_nx;
    logic [WIDTH-1:0] fall_nx;
    logic [WIDTH-1:0] clr;
    logic             armed;

    // Open-drain channels only ever pull low; a high OUT releases the pad.
    assign drv_en  = oe_q & (~od_q | ~out_q);
    assign drv_val = out_q & ~od_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pad
        assign io[gi] = drv_en[gi] ? drv_val[gi] : 1'bz;
        if (PULLUP_MASK[gi]) begin : g_pu
            pullup (io[gi]);
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];
    assign armed   = (warm_q == 3'd0);
    assign rise_nx = armed ? (in_sync & ~prev_q) : '0;
    assign fall_nx = armed ? (~in_sync & prev_q) : '0;
    assign clr     = (wr_en && addr == 3'd4) ? wr_data : '0;
    assign irq     = |(status_q & ien_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            oe_q     <= '0;
            od_q     <= '0;
            ien_q    <= '0;
            status_q <= '0;
            prev_q   <= '0;
            rise     <= '0;
            fall     <= '0;
            warm_q   <= WARM;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= io;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= in_sync;
            rise   <= rise_nx;
            fall   <= fall_nx;
            if (!armed) begin
                warm_q <= warm_q - 3'd1;
            end
            // A new edge wins over a coincident clear.
            status_q <= (status_q & ~clr) | rise_nx | fall_nx;
            if (wr_en) begin
                case (addr)
                    3'd0:    out_q <= wr_data;
                    3'd1:    oe_q  <= wr_data;
                    3'd2:    od_q  <= wr_data;
                    3'd3:    ien_q <= wr_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            3'd0:    rd_data = out_q;
            3'd1:    rd_data = oe_q;
            3'd2:    rd_data = od_q;
            3'd3:    rd_data = ien_q;
            3'd4:    rd_data = status_q;
            3'd5:    rd_data = in_sync;
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_iobank.sv
// tb_gpio_iobank: directed bench for gpio_iobank (WIDTH=8, SYNC_STAGES=2).
// Expectations are queued when stimulus is applied and popped at check time.
module tb_gpio_iobank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic [7:0] in_sync;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       irq;
    wire  [7:0] io;
    logic [7:0] ext_oe = 8'h00;
    logic [7:0] ext_val = 8'h00;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 8; gi++) begin : g_ext
        assign io[gi] = ext_oe[gi] ? ext_val[gi] : 1'bz;
    end

    gpio_iobank #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .PULLUP_MASK(8'hFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .addr(addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .io(io),
        .in_sync(in_sync),
        .rise(rise),
        .fall(fall),
        .irq(irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v);
        addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic expect_v(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] acc;

        // reset with floating pads
        expect_v("rst_io", 8'hFF);
        expect_v("rst_irq", 8'h00);
        expect_v("rst_rise", 8'h00);
        tick();
        tick();
        chk(io);
        chk({7'd0, irq});
        chk(rise);
        rst = 1'b0;
        expect_v("warm_insync", 8'hFF);
        tick();
        tick();
        chk(in_sync);
        expect_v("warm_no_edge", 8'h00);
        acc = 8'h00;
        for (int i = 0; i < 6; i++) begin
            acc = acc | rise | fall;
            tick();
        end
        chk(acc);
        expect_v("warm_status", 8'h00);
        rd(3'd4, v);
        chk(v);

        // push-pull drive on low nibble
        expect_v("pp_io", 8'hF5);
        expect_v("pp_insync", 8'hF5);
        expect_v("pp_fall_early", 8'h00);
        expect_v("pp_fall", 8'h0A);
        expect_v("pp_rise", 8'h00);
        expect_v("pp_fall_end", 8'h00);
        expect_v("pp_status", 8'h0A);
        expect_v("pp_irq", 8'h00);
        wr(3'd0, 8'h05);
        wr(3'd1, 8'h0F);
        chk(io);
        tick();
        tick();
        chk(in_sync);
        chk(fall);
        tick();
        chk(fall);
        chk(rise);
        tick();
        chk(fall);
        rd(3'd4, v);
        chk(v);
        chk({7'd0, irq});
        expect_v("w1c_all", 8'h00);
        wr(3'd4, 8'hFF);
        rd(3'd4, v);
        chk(v);

        // open-drain on high nibble
        expect_v("od_io", 8'h3F);
        expect_v("od_insync", 8'h3F);
        expect_v("od_rd_in", 8'h3F);
        expect_v("od_clr", 8'h00);
        wr(3'd2, 8'hF0);
        wr(3'd1, 8'hF0);
        wr(3'd0, 8'h30);
        for (int i = 0; i < 5; i++) tick();
        chk(io);
        chk(in_sync);
        rd(3'd5, v);
        chk(v);
        wr(3'd4, 8'hFF);
        rd(3'd4, v);
        chk(v);

        // external pulse on io[0] with irq enabled
        expect_v("x0_fall", 8'h01);
        expect_v("x0_fall_rise", 8'h00);
        expect_v("x0_irq", 8'h01);
        expect_v("x0_fall_end", 8'h00);
        expect_v("x0_rise", 8'h01);
        expect_v("x0_status", 8'h01);
        expect_v("x0_irq_clr", 8'h00);
        expect_v("x0_status_clr", 8'h00);
        wr(3'd3, 8'h01);
        ext_oe[0]  = 1'b1;
        ext_val[0] = 1'b0;
        tick();
        tick();
        tick();
        chk(fall);
        chk(rise);
        chk({7'd0, irq});
        tick();
        chk(fall);
        ext_val[0] = 1'b1;
        tick();
        tick();
        tick();
        chk(rise);
        tick();
        rd(3'd4, v);
        chk(v);
        wr(3'd4, 8'h01);
        chk({7'd0, irq});
        rd(3'd4, v);
        chk(v);
        ext_oe[0] = 1'b0;

        // clear coinciding with rise on bit 2
        expect_v("sw_rise", 8'h04);
        expect_v("sw_status", 8'h04);
        ext_oe[2]  = 1'b1;
        ext_val[2] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        wr(3'd4, 8'hFF);
        ext_val[2] = 1'b1;
        tick();
        tick();
        wr(3'd4, 8'h04);
        chk(rise);
        rd(3'd4, v);
        chk(v);
        ext_oe[2] = 1'b0;

        // reset right after an io[5] toggle, with a write held
        expect_v("mr_io", 8'hFF);
        expect_v("mr_irq", 8'h00);
        expect_v("mr_no_edge5", 8'h00);
        expect_v("mr_oe", 8'h00);
        expect_v("mr_addr6", 8'h00);
        wr(3'd0, 8'h10);
        rst     = 1'b1;
        wr_en   = 1'b1;
        addr    = 3'd1;
        wr_data = 8'hFF;
        tick();
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        chk(io);
        chk({7'd0, irq});
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            acc = acc | ((rise | fall) & 8'h20);
        end
        chk(acc);
        rd(3'd1, v);
        chk(v);
        wr(3'd6, 8'hFF);
        rd(3'd6, v);
        chk(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_iobank.md
GPIO_IOBANK -- requirements
Module: gpio_iobank

Interface
REQ-001 Parameter WIDTH, default 8, number of bidirectional pad channels (legal 1..32).
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth (legal 2..4).
REQ-003 Parameter PULLUP_MASK, default all ones of WIDTH bits: channel i has a pullup when bit i is 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 wr_en  input  1  register write strobe.
REQ-007 addr  input  3  register address for both write and read.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 rd_data  output  WIDTH  combinational read data for addr.
REQ-010 io  inout  WIDTH  pad lines, tristate, per-channel drive.
REQ-011 in_sync  output  WIDTH  synchronized pad values.
REQ-012 rise  output  WIDTH  one-cycle pulse per channel on synchronized 0->1.
REQ-013 fall  output  WIDTH  one-cycle pulse per channel on synchronized 1->0.
REQ-014 irq  output  1  OR of (STATUS & IRQ_EN).

Function
REQ-015 The register map SHALL be: 0 OUT, 1 OE, 2 OD (open-drain enable), 3 IRQ_EN, 4 STATUS (write-1-to-clear), 5 IN (read-only, in_sync); addresses 6..7 read 0 and ignore writes.
REQ-016 A write to addresses 0..3 SHALL update the register at the clock edge where wr_en is high; new drive appears on io after that edge.
REQ-017 Pad drive per channel SHALL be: OE=0 -> z; OE=1, OD=0 -> OUT; OE=1, OD=1 -> 0 when OUT=0, z when OUT=1.
REQ-018 A channel whose PULLUP_MASK bit is 1 SHALL resolve to 1 whenever undriven on chip and off chip.
REQ-019 in_sync[i] SHALL reflect a stable pad change exactly SYNC_STAGES clock edges after the change.
REQ-020 rise/fall SHALL be registered: asserted for exactly one cycle, one edge after in_sync changes (SYNC_STAGES+1 edges after pad change).
REQ-021 STATUS[i] SHALL set on the same edge rise[i] or fall[i] asserts, and stay set until cleared.
REQ-022 Writing 1 to STATUS bit i SHALL clear it; if an edge event on i coincides with the clear, set SHALL win.
REQ-023 irq SHALL be combinational from STATUS and IRQ_EN; changing IRQ_EN SHALL not alter STATUS.
REQ-024 A warm-up counter SHALL suppress rise, fall and STATUS setting for SYNC_STAGES+1 cycles after reset deassertion; synchronizer still shifts during warm-up.
REQ-025 Driven output channels SHALL loop back through the synchronizer (in_sync shows own drive) and generate edges like inputs.
REQ-026 Width arithmetic SHALL be bitwise per channel; no channel interaction except irq reduction.

Reset
REQ-027 While rst is high at a clock edge: OUT, OE, OD, IRQ_EN, STATUS, rise, fall, all synchronizer stages and the previous-value register SHALL become 0; warm-up counter SHALL reload.
REQ-028 During and after reset, all io SHALL be z (pulled channels read 1); irq SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard in-flight edges; no rise/fall pulse SHALL emerge from pre-reset pad activity.
REQ-030 Writes with wr_en high during reset SHALL be ignored.

Verification (WIDTH=8, SYNC_STAGES=2, PULLUP_MASK=8'hFF)
REQ-031 Reset, external pads floating -> io reads 8'hFF, in_sync 8'hFF by cycle 2, no rise pulse at any time, STATUS=0, irq=0.
REQ-032 Write OE=8'h0F, OUT=8'h05 -> io=8'hF5 next cycle; in_sync=8'hF5 two edges later; fall on bits 1,3 one edge after that, STATUS=8'h0A.
REQ-033 Write OD=8'hF0, OE=8'hF0, OUT=8'h30 -> bits 7:6 driven 0, bits 5:4 z read 1, io[7:4]=4'h3.
REQ-034 External driver pulls io[0] 1->0->1 with IRQ_EN=8'h01 -> fall then rise one-cycle pulses, STATUS[0]=1, irq=1; write STATUS=8'h01 -> irq=0.
REQ-035 Write-1-to-clear STATUS[2] on the same edge rise[2] asserts -> STATUS[2] remains 1.
REQ-036 Assert rst one cycle after an io[5] toggle -> no rise/fall on bit 5 after reset; OE=0, io returns to 8'hFF.
